// File: rtl/io_mmio_bank_pkg.sv
// ============================================================================
// Module   : io_mmio_pkg
// Brief    : Register offsets and default window base for the MMIO I/O bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package io_mmio_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FF00;

   localparam logic [7:0] OFF_OUT        = 8'h00;
   localparam logic [7:0] OFF_OUT_SET    = 8'h04;
   localparam logic [7:0] OFF_OUT_CLR    = 8'h08;
   localparam logic [7:0] OFF_IN         = 8'h0C;
   localparam logic [7:0] OFF_IN_EDGE    = 8'h10;
   localparam logic [7:0] OFF_PWM_EN     = 8'h14;
   localparam logic [7:0] OFF_PWM_PERIOD = 8'h18;
   localparam logic [7:0] OFF_PWM_DUTY0  = 8'h20;

endpackage

`default_nettype wire

// File: rtl/io_mmio_bank_pwm_channel.sv
// ============================================================================
// Module   : pwm_channel
// Brief    : One PWM pin; duty reloads from the shadow on wrap or while idle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_channel #(
   parameter int PWM_W = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [PWM_W-1:0] cnt,
   input  logic             wrap,
   input  logic             en,
   input  logic [PWM_W-1:0] duty,
   output logic             pwm
);

   logic [PWM_W-1:0] r_duty_act;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_duty_act <= '0;
      end else if (wrap || !en) begin
         r_duty_act <= duty;
      end
   end

   assign pwm = en & (cnt < r_duty_act);

endmodule

`default_nettype wire

// File: rtl/io_mmio_bank.sv
// ============================================================================
// Module   : io_mmio_bank
// Brief    : Memory-mapped output/input/PWM register window with passthrough.
// Revision : 1.0
// ============================================================================
`default_nettype none

module io_mmio_bank
   import io_mmio_pkg::*;
#(
   parameter int          NUM_PWM   = 4,
   parameter int          PWM_W     = 16,
   parameter int          IN_W      = 32,
   parameter int          OUT_W     = 32,
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               write_mem,
   input  logic               read_mem,
   input  logic [31:0]        data_address,
   input  logic [31:0]        data_to_write,
   input  logic [31:0]        data_from_mem,
   output logic [31:0]        data_read,
   input  logic [IN_W-1:0]    IO_in,
   output logic [OUT_W-1:0]   IO_out,
   output logic [NUM_PWM-1:0] IO_pwm
);

   logic               w_hit;
   logic               w_wr;
   logic [7:0]         w_off;
   logic               w_wrap;
   logic               w_period_wr;
   logic [IN_W-1:0]    w_rise;
   logic [IN_W-1:0]    w_edge_clr;
   logic [31:0]        w_reg;
   logic               w_unused;
   logic [PWM_W-1:0]   w_duty [NUM_PWM];

   logic [OUT_W-1:0]   r_out;
   logic [IN_W-1:0]    r_sync1;
   logic [IN_W-1:0]    r_sync2;
   logic [IN_W-1:0]    r_sync2_d;
   logic [IN_W-1:0]    r_edge;
   logic [NUM_PWM-1:0] r_en;
   logic [PWM_W-1:0]   r_period;
   logic [PWM_W-1:0]   r_cnt;

   assign w_hit       = (data_address[31:8] == BASE_ADDR[31:8]);
   assign w_off       = {data_address[7:2], 2'b00};
   assign w_wr        = w_hit & write_mem;
   assign w_period_wr = w_wr && (w_off == OFF_PWM_PERIOD);
   assign w_wrap      = (r_cnt == r_period);
   assign w_rise      = r_sync2 & ~r_sync2_d;
   assign w_edge_clr  = (w_wr && (w_off == OFF_IN_EDGE)) ? data_to_write[IN_W-1:0] : '0;
   assign w_unused    = &{1'b0, data_address[1:0], data_to_write};

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_out    <= '0;
         r_en     <= '0;
         r_period <= '0;
      end else if (w_wr) begin
         case (w_off)
            OFF_OUT:        r_out    <= data_to_write[OUT_W-1:0];
            OFF_OUT_SET:    r_out    <= r_out | data_to_write[OUT_W-1:0];
            OFF_OUT_CLR:    r_out    <= r_out & ~data_to_write[OUT_W-1:0];
            OFF_PWM_EN:     r_en     <= data_to_write[NUM_PWM-1:0];
            OFF_PWM_PERIOD: r_period <= data_to_write[PWM_W-1:0];
            default:        ;
         endcase
      end
   end

   // Hardware set wins over a W1C clear landing in the same cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_sync2_d <= '0;
         r_edge    <= '0;
      end else begin
         r_sync1   <= IO_in;
         r_sync2   <= r_sync1;
         r_sync2_d <= r_sync2;
         r_edge    <= (r_edge & ~w_edge_clr) | w_rise;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt <= '0;
      end else if (w_period_wr || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + {{(PWM_W-1){1'b0}}, 1'b1};
      end
   end

   for (genvar i = 0; i < NUM_PWM; i++) begin : g_pwm
      localparam logic [7:0] c_duty_off = OFF_PWM_DUTY0 + 8'(4 * i);
      logic [PWM_W-1:0] r_duty;

      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            r_duty <= '0;
         end else if (w_wr && (w_off == c_duty_off)) begin
            r_duty <= data_to_write[PWM_W-1:0];
         end
      end

      assign w_duty[i] = r_duty;

      pwm_channel #(
         .PWM_W (PWM_W)
      ) u_pwm_channel (
         .clk  (clk),
         .nrst (nrst),
         .cnt  (r_cnt),
         .wrap (w_wrap),
         .en   (r_en[i]),
         .duty (r_duty),
         .pwm  (IO_pwm[i])
      );
   end

   always_comb begin
      w_reg = '0;
      case (w_off)
         OFF_OUT:        w_reg[OUT_W-1:0]   = r_out;
         OFF_IN:         w_reg[IN_W-1:0]    = r_sync2;
         OFF_IN_EDGE:    w_reg[IN_W-1:0]    = r_edge;
         OFF_PWM_EN:     w_reg[NUM_PWM-1:0] = r_en;
         OFF_PWM_PERIOD: w_reg[PWM_W-1:0]   = r_period;
         default: begin
            for (int i = 0; i < NUM_PWM; i++) begin
               if (w_off == (OFF_PWM_DUTY0 + 8'(4 * i))) begin
                  w_reg[PWM_W-1:0] = w_duty[i];
               end
            end
         end
      endcase
   end

   assign data_read = (w_hit && read_mem) ? w_reg : data_from_mem;
   assign IO_out    = r_out;

endmodule

`default_nettype wire

// File: tb/tb_io_mmio_bank.sv
// ============================================================================
// Module   : tb_io_mmio_bank
// Brief    : Directed self-checking bench for io_mmio_bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_io_mmio_bank;

   logic        clk = 1'b0;
   logic        nrst;
   logic        write_mem;
   logic        read_mem;
   logic [31:0] data_address;
   logic [31:0] data_to_write;
   logic [31:0] data_from_mem;
   logic [31:0] data_read;
   logic [31:0] IO_in;
   logic [31:0] IO_out;
   logic [3:0]  IO_pwm;

   int n_pass  = 0;
   int n_total = 0;
   int hc;

   always #5 clk = ~clk;

   io_mmio_bank u_dut (
      .clk           (clk),
      .nrst          (nrst),
      .write_mem     (write_mem),
      .read_mem      (read_mem),
      .data_address  (data_address),
      .data_to_write (data_to_write),
      .data_from_mem (data_from_mem),
      .data_read     (data_read),
      .IO_in         (IO_in),
      .IO_out        (IO_out),
      .IO_pwm        (IO_pwm)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      data_address  = {24'hFFFFFF, off};
      data_to_write = d;
      write_mem     = 1'b1;
      @(posedge clk);
      #1;
      write_mem     = 1'b0;
      data_address  = 32'h0000_1000;
   endtask

   task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
      data_address = {24'hFFFFFF, off};
      read_mem     = 1'b1;
      #1;
      check(tag, data_read, exp);
      read_mem     = 1'b0;
      data_address = 32'h0000_1000;
   endtask

   task automatic count_high(input int n, output int c);
      c = 0;
      repeat (n) begin
         step();
         if (IO_pwm[0]) c = c + 1;
      end
   endtask

   task automatic wait_rise();
      logic prev;
      logic found;
      prev  = IO_pwm[0];
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (IO_pwm[0] && !prev) found = 1'b1;
         prev = IO_pwm[0];
      end
      check("pwm_rise_timeout", {31'd0, found}, 32'd1);
   endtask

   task automatic wait_high();
      logic found;
      found = IO_pwm[0];
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         found = IO_pwm[0];
      end
      check("pwm_high_timeout", {31'd0, found}, 32'd1);
   endtask

   initial begin
      nrst          = 1'b0;
      write_mem     = 1'b0;
      read_mem      = 1'b0;
      data_address  = 32'h0000_1000;
      data_to_write = '0;
      data_from_mem = 32'hDEAD_BEEF;
      IO_in         = '0;
      repeat (3) @(posedge clk);
      #1;
      nrst = 1'b1;

      // Reset state and passthrough
      check("rst_io_out", IO_out, 32'h0);
      check("rst_io_pwm", {28'd0, IO_pwm}, 32'h0);
      rd("rst_pwm_en", 8'h14, 32'h0);
      data_address = 32'h0000_1000;
      read_mem     = 1'b1;
      #1;
      check("passthru_miss", data_read, 32'hDEAD_BEEF);
      read_mem     = 1'b0;
      data_address = 32'hFFFF_FF00;
      #1;
      check("passthru_no_strobe", data_read, 32'hDEAD_BEEF);
      data_address = 32'h0000_1000;

      // Output register set/clear
      wr(8'h00, 32'h0000_000F);
      check("out_write", IO_out, 32'h0000_000F);
      wr(8'h04, 32'h0000_00F0);
      check("out_set", IO_out, 32'h0000_00FF);
      wr(8'h08, 32'h0000_0003);
      check("out_clr", IO_out, 32'h0000_00FC);
      rd("out_read", 8'h00, 32'h0000_00FC);
      rd("unmapped_1c", 8'h1C, 32'h0);

      // Simultaneous read and write shows the pre-write value
      step();
      data_address  = 32'hFFFF_FF00;
      data_to_write = 32'h0000_00FF;
      write_mem     = 1'b1;
      read_mem      = 1'b1;
      #1;
      check("rw_prewrite", data_read, 32'h0000_00FC);
      @(posedge clk);
      #1;
      write_mem    = 1'b0;
      read_mem     = 1'b0;
      data_address = 32'h0000_1000;
      check("rw_written", IO_out, 32'h0000_00FF);

      // Input synchroniser and sticky edge
      IO_in = 32'h8;
      step();
      rd("in_after_1", 8'h0C, 32'h0);
      step();
      rd("in_after_2", 8'h0C, 32'h8);
      rd("edge_after_2", 8'h10, 32'h0);
      step();
      rd("edge_after_3", 8'h10, 32'h8);
      wr(8'h10, 32'h8);
      rd("edge_w1c", 8'h10, 32'h0);
      IO_in = 32'h0;
      repeat (3) step();
      rd("edge_fall_ignored", 8'h10, 32'h0);
      IO_in = 32'h8;
      step();
      step();
      wr(8'h10, 32'h8);
      rd("edge_set_beats_clr", 8'h10, 32'h8);
      wr(8'h10, 32'h8);
      rd("edge_w1c_again", 8'h10, 32'h0);

      // PWM basic: period 9, duty 3
      wr(8'h18, 32'd9);
      wr(8'h20, 32'd3);
      wr(8'h14, 32'h1);
      count_high(10, hc);
      check("pwm_duty3_count", hc, 32'd3);
      check("pwm_other_ch_low", {28'd0, IO_pwm[3:1], 1'b0}, 32'h0);

      // Duty change mid-period takes effect at next cnt = 0
      wait_rise();
      repeat (4) step();
      wr(8'h20, 32'd7);
      check("pwm_mid_no_glitch", {31'd0, IO_pwm[0]}, 32'd0);
      rd("duty0_shadow", 8'h20, 32'd7);
      count_high(4, hc);
      check("pwm_old_tail", hc, 32'd0);
      count_high(10, hc);
      check("pwm_duty7_count", hc, 32'd7);

      // PWM edge cases
      wr(8'h20, 32'd0);
      repeat (12) step();
      count_high(10, hc);
      check("pwm_duty0_low", hc, 32'd0);
      wr(8'h20, 32'd12);
      repeat (12) step();
      count_high(10, hc);
      check("pwm_duty_gt_period", hc, 32'd10);
      wr(8'h20, 32'd1);
      wr(8'h18, 32'd0);
      repeat (3) step();
      count_high(10, hc);
      check("pwm_period0_high", hc, 32'd10);
      rd("period_read", 8'h18, 32'd0);
      wr(8'h30, 32'd5);
      rd("duty4_unmapped", 8'h30, 32'd0);
      rd("duty0_no_alias", 8'h20, 32'd1);
      rd("duty3_read", 8'h2C, 32'd0);
      wr(8'h14, 32'h0);
      check("pwm_en0_low", {28'd0, IO_pwm}, 32'h0);
      count_high(5, hc);
      check("pwm_en0_count", hc, 32'd0);

      // Asynchronous reset mid-period
      IO_in = 32'h0;
      wr(8'h18, 32'd9);
      wr(8'h20, 32'd5);
      wr(8'h14, 32'h1);
      wait_high();
      check("pre_rst_out", IO_out, 32'h0000_00FF);
      #3;
      nrst = 1'b0;
      #1;
      check("async_rst_out", IO_out, 32'h0);
      check("async_rst_pwm", {28'd0, IO_pwm}, 32'h0);
      step();
      step();
      nrst = 1'b1;
      rd("post_rst_out", 8'h00, 32'h0);
      rd("post_rst_in", 8'h0C, 32'h0);
      rd("post_rst_edge", 8'h10, 32'h0);
      rd("post_rst_en", 8'h14, 32'h0);
      rd("post_rst_period", 8'h18, 32'h0);
      rd("post_rst_duty0", 8'h20, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
